// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: buffers host opcodes in a FIFO and issues them one at a
// time to the LCD image controller, following its busy/done handshake.
// A command counts as accepted when the controller raises busy the cycle after
// the strobe; otherwise it counts as ignored.
// Optional build macro LCD_SEQ_FILTER_EN: host opcodes 12-15 are handshaken but
// dropped at the FIFO input, and each one counts as ignored.
module lcd_cmd_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    host_cmd,
  input  logic          host_valid,
  output logic          host_ready,
  output logic [3:0]    cmd,
  output logic          cmd_valid,
  input  logic          busy,
  input  logic          done,
  output logic [AW:0]   fifo_level,
  output logic [7:0]    issued_cnt,
  output logic [3:0]    ign_cnt,
  output logic          seq_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_CHECK     = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [AW:0]   LEVEL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  // Saturating add for the 4-bit ignore counter (up to two events per cycle).
  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [1:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {3'b000, b};
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    issued_q, issued_d;
  logic [3:0]    ign_q, ign_d;
  logic          seq_done_q, seq_done_d;

  logic          full_s;
  logic          empty_s;
  logic          host_ready_s;
  logic          push_s;
  logic          wr_en_s;
  logic          filt_drop_s;
  logic          pop_s;
  logic          acc_s;
  logic          ign_s;

  assign full_s       = (level_q == LEVEL_MAX);
  assign empty_s      = (level_q == '0);
  assign host_ready_s = !full_s && (state_q != S_FINISH);
  assign push_s       = host_valid && host_ready_s;

`ifdef LCD_SEQ_FILTER_EN
  // Illegal opcodes complete the host handshake but never occupy a FIFO slot.
  assign wr_en_s     = push_s && (host_cmd < 4'd12);
  assign filt_drop_s = push_s && (host_cmd >= 4'd12);
`else
  assign wr_en_s     = push_s;
  assign filt_drop_s = 1'b0;
`endif

  // Next-state logic for the issue FSM and its pop/accept/ignore strobes.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    acc_s   = 1'b0;
    ign_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (done) begin
          state_d = S_FINISH;
        end else if (!busy && !empty_s) begin
          pop_s   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (busy) begin
          acc_s   = 1'b1;
          state_d = S_WAIT_IDLE;
        end else begin
          ign_s   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (done) begin
          state_d = S_FINISH;
        end else if (!busy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_FINISH: begin
        state_d = S_FINISH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer/level and output register next-state values.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    cmd_d       = cmd_q;
    cmd_valid_d = pop_s;
    issued_d    = issued_q;
    ign_d       = sat_add4(ign_q, {1'b0, ign_s} + {1'b0, filt_drop_s});
    seq_done_d  = (state_d == S_FINISH);
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      cmd_d    = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
    if (acc_s && (issued_q != 8'hFF)) begin
      issued_d = issued_q + 8'd1;
    end else begin
      issued_d = issued_q;
    end
  end

  // FIFO storage; contents become unreachable when the pointers reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= host_cmd;
    end
  end

  // State, pointer, counter and output registers with async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cmd_q       <= 4'd0;
      cmd_valid_q <= 1'b0;
      issued_q    <= 8'd0;
      ign_q       <= 4'd0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      issued_q    <= issued_d;
      ign_q       <= ign_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign host_ready = host_ready_s;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign fifo_level = level_q;
  assign issued_cnt = issued_q;
  assign ign_cnt    = ign_q;
  assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: a transaction-level model
// (opcode queue + issue/accept bookkeeping) is compared against the DUT on
// every falling edge, plus literal expectations for the directed scenarios.
module tb_lcd_cmd_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic [3:0]    host_cmd;
  logic          host_valid;
  logic          host_ready;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   fifo_level;
  logic [7:0]    issued_cnt;
  logic [3:0]    ign_cnt;
  logic          seq_done;

  logic          ext_busy;
  logic          ctrl_busy;
  logic          done_mode;

  int n_chk  = 0;
  int n_pass = 0;

  lcd_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .fifo_level (fifo_level),
    .issued_cnt (issued_cnt),
    .ign_cnt    (ign_cnt),
    .seq_done   (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign busy = ctrl_busy | ext_busy;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
  endtask

  // ---------------- controller model ----------------
  // Legal opcodes (0-11): busy rises the cycle after the strobe is sampled and
  // stays high for a random 1-3 cycles; in done_mode opcode 0 holds busy for
  // 64 cycles and then raises done. Illegal opcodes get no response.
  logic       c_cv;
  logic [3:0] c_cmd;
  int         c_hold = 0;
  logic       c_zero = 1'b0;

  always @(posedge clk) begin
    c_cv  = cmd_valid;
    c_cmd = cmd;
    #1;
    if (!reset) begin
      ctrl_busy = 1'b0;
      c_hold    = 0;
      c_zero    = 1'b0;
      done      = 1'b0;
    end else if (c_cv && (c_cmd < 4'd12)) begin
      ctrl_busy = 1'b1;
      c_zero    = done_mode && (c_cmd == 4'd0);
      c_hold    = c_zero ? 64 : int'($urandom_range(3, 1));
    end else if (c_hold > 0) begin
      c_hold--;
      if (c_hold == 0) begin
        if (c_zero) done = 1'b1;
        else ctrl_busy = 1'b0;
      end
    end
  end

  // ---------------- behavioural reference model ----------------
  logic [3:0] mq[$];
  logic [3:0] m_cmd;
  logic       m_cv, m_fin, m_pend, m_wait;
  int         m_age, m_iss, m_ign;
  logic       rec_hv, rec_bz, rec_dn;
  logic [3:0] rec_hc;
  logic       was_pend, was_wait, ready_pre, pop;

  initial begin
    m_cmd = 4'd0; m_cv = 1'b0; m_fin = 1'b0; m_pend = 1'b0; m_wait = 1'b0;
    m_age = 0; m_iss = 0; m_ign = 0;
    rec_hv = 1'b0; rec_bz = 1'b0; rec_dn = 1'b0; rec_hc = 4'd0;
  end

  // Inputs seen at one falling edge are those sampled at the next rising edge,
  // so each falling edge applies the edge just passed using the previous record.
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      m_cmd = 4'd0; m_cv = 1'b0; m_fin = 1'b0; m_pend = 1'b0; m_wait = 1'b0;
      m_age = 0; m_iss = 0; m_ign = 0;
    end else begin
      was_pend  = m_pend;
      was_wait  = m_wait;
      ready_pre = (mq.size() < DEPTH) && !m_fin;
      pop = !m_fin && !was_pend && !was_wait && !rec_dn && !rec_bz && (mq.size() > 0);
      if (rec_dn && !was_pend) m_fin = 1'b1;
      if (was_pend) begin
        m_age++;
        if (m_age == 2) begin
          m_pend = 1'b0;
          if (rec_bz) begin
            if (m_iss < 255) m_iss++;
            m_wait = 1'b1;
          end else begin
            if (m_ign < 15) m_ign++;
          end
        end
      end
      if (was_wait && !rec_bz) m_wait = 1'b0;
      m_cv = pop;
      if (pop) begin
        m_cmd  = mq.pop_front();
        m_pend = 1'b1;
        m_age  = 0;
      end
      if (rec_hv && ready_pre) begin
`ifdef LCD_SEQ_FILTER_EN
        if (rec_hc >= 4'd12) begin
          if (m_ign < 15) m_ign++;
        end else begin
          mq.push_back(rec_hc);
        end
`else
        mq.push_back(rec_hc);
`endif
      end
    end
    chk("cmd_valid",  int'(cmd_valid),  int'(m_cv));
    chk("cmd",        int'(cmd),        int'(m_cmd));
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("host_ready", int'(host_ready), int'((mq.size() < DEPTH) && !m_fin));
    chk("issued_cnt", int'(issued_cnt), m_iss);
    chk("ign_cnt",    int'(ign_cnt),    m_ign);
    chk("seq_done",   int'(seq_done),   int'(m_fin));
    rec_hv = host_valid;
    rec_hc = host_cmd;
    rec_bz = busy;
    rec_dn = done;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op);
    host_cmd   = op;
    host_valid = 1'b1;
    cyc();
    host_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if ((mq.size() == 0) && !m_pend && !m_wait) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
    repeat (2) cyc();
  endtask

  // ---------------- directed and random scenarios ----------------
  initial begin
    logic seen;
    reset = 1'b0; host_valid = 1'b0; host_cmd = 4'd0;
    ext_busy = 1'b0; done_mode = 1'b0; ctrl_busy = 1'b0; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_issued", int'(issued_cnt), 0);
    reset = 1'b1;

    // start-up: controller busy while loading, then {1,4} issued in order
    ext_busy = 1'b1;
    push(4'd1);
    push(4'd4);
    repeat (70) cyc();
    chk("startup_level", int'(fifo_level), 2);
    chk("startup_issued_before", int'(issued_cnt), 0);
    ext_busy = 1'b0;
    wait_drain("startup_drain", 100);
    chk("startup_issued", int'(issued_cnt), 2);
    chk("startup_model_issued", m_iss, 2);

    // fill FIFO while busy, 17th offer refused
    ext_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(4'($urandom_range(11, 1)));
    chk("fill_level", int'(fifo_level), 16);
    chk("fill_ready", int'(host_ready), 0);
    push(4'd9);
    chk("fill_level_17", int'(fifo_level), 16);
    ext_busy = 1'b0;
    wait_drain("fill_drain", 200);
    chk("fill_issued", int'(issued_cnt), 18);
    chk("fill_level_empty", int'(fifo_level), 0);

    // illegal opcode 13 then 2
    do_reset();
    push(4'd13);
    push(4'd2);
    wait_drain("illegal_drain", 50);
    chk("illegal_ign", int'(ign_cnt), 1);
    chk("illegal_issued", int'(issued_cnt), 1);
    chk("illegal_last_cmd", int'(cmd), 2);

    // randomized traffic with occasional external busy
    for (int i = 0; i < 400; i++) begin
      host_valid = 1'($urandom_range(1, 0));
      host_cmd   = 4'($urandom_range(15, 1));
      ext_busy   = ($urandom_range(7, 0) == 0);
      cyc();
    end
    host_valid = 1'b0;
    ext_busy   = 1'b0;
    wait_drain("random_drain", 300);

    // reset while a command strobe is out
    push(4'd3);
    push(4'd5);
    push(4'd6);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst_saw_issue", int'(seen), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_cmd_valid", int'(cmd_valid), 0);
    chk("midrst_level", int'(fifo_level), 0);
    chk("midrst_issued", int'(issued_cnt), 0);
    chk("midrst_ign", int'(ign_cnt), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    push(4'd2);
    wait_drain("midrst_drain", 50);
    chk("midrst_resume_issued", int'(issued_cnt), 1);

    // saturation of both counters
    do_reset();
    host_valid = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      host_cmd = 4'($urandom_range(11, 1));
      cyc();
    end
    host_valid = 1'b0;
    wait_drain("sat_drain", 300);
    chk("sat_issued", int'(issued_cnt), 255);
    for (int i = 0; i < 20; i++) begin
      push(4'd13);
      repeat (3) cyc();
    end
    wait_drain("sat_ign_drain", 100);
    chk("sat_ign", int'(ign_cnt), 15);
    chk("sat_model_ign", m_ign, 15);

    // write-out opcode 0 followed by done: terminal, 5 stays queued
    do_reset();
    done_mode = 1'b1;
    push(4'd7);
    push(4'd0);
    push(4'd5);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (seq_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("finish_reached", int'(seen), 1);
    repeat (3) cyc();
    push(4'd9);
    repeat (5) cyc();
    chk("finish_seq_done", int'(seq_done), 1);
    chk("finish_level", int'(fifo_level), 1);
    chk("finish_ready", int'(host_ready), 0);
    chk("finish_cmd_valid", int'(cmd_valid), 0);
    chk("finish_issued", int'(issued_cnt), 2);
    chk("finish_last_cmd", int'(cmd), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
